cu_seq_ctrl: RTL and testbench

- Parametrised successor to the 8-bit microcontroller control unit: a multi-cycle fetch/decode/execute sequencer.
- Handshaked flash fetch, registered register-file read stage, latched ALU flags, variable-latency SRAM loads with timeout, and a persistent GPIO output register.
- Sits between the program counter, flash, register file, ALU, SRAM and GPIO.
- Instruction format: 16 bits, fetched high byte first. Fields: opcode[15:12], dst[11:8], a[7:4], b[3:0].

---
 rtl/cu_seq_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_cu_seq_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cu_seq_ctrl.sv
// cu_seq_ctrl: multi-cycle fetch/decode/execute sequencer for the 8-bit MCU core.
// Fetches a 16-bit instruction from flash (high byte first), reads the register
// file, drives the ALU/SRAM/GPIO and issues one-cycle write/PC pulses in WB.
// Optional build macro CU_SEQ_STEP_EN adds dbg_halt/dbg_step single-step control.
module cu_seq_ctrl #(
    parameter int DATA_W       = 8,
    parameter int PC_W         = 12,
    parameter int LOAD_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
`ifdef CU_SEQ_STEP_EN
    input  logic              dbg_halt,
    input  logic              dbg_step,
`endif
    input  logic [7:0]        flash_data,
    input  logic              flash_valid,
    output logic              pc_inc,
    output logic              pc_load,
    output logic [PC_W-1:0]   pc_next,
    output logic [3:0]        reg_read_addr_a,
    output logic [3:0]        reg_read_addr_b,
    input  logic [DATA_W-1:0] reg_read_data_a,
    input  logic [DATA_W-1:0] reg_read_data_b,
    output logic              reg_write_en,
    output logic [3:0]        reg_write_addr,
    output logic [DATA_W-1:0] reg_write_data,
    output logic [2:0]        alu_opcode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_eq,
    input  logic              alu_gt,
    input  logic              alu_cout,
    output logic [7:0]        sram_addr,
    output logic              sram_read_en,
    input  logic              sram_rvalid,
    input  logic [DATA_W-1:0] sram_read_data,
    output logic              sram_write_en,
    output logic [DATA_W-1:0] sram_write_data,
    input  logic [DATA_W-1:0] in_gpio,
    output logic [DATA_W-1:0] out_gpio,
    output logic [2:0]        flags,
    output logic              mem_err,
    output logic [2:0]        state_o
);

    typedef enum logic [2:0] {
        FETCH_HI = 3'd0,
        FETCH_LO = 3'd1,
        DECODE   = 3'd2,
        EXEC     = 3'd3,
        MEM_WAIT = 3'd4,
        WB       = 3'd5
    } state_t;

    localparam logic [3:0] OP_LOAD  = 4'b1000;
    localparam logic [3:0] OP_STORE = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1010;
    localparam logic [3:0] OP_BEQ   = 4'b1011;
    localparam logic [3:0] OP_BGT   = 4'b1100;
    localparam logic [3:0] OP_BC    = 4'b1101;
    localparam logic [3:0] OP_IN    = 4'b1110;
    localparam logic [3:0] OP_OUT   = 4'b1111;
    localparam int         JMP_W    = (PC_W < 12) ? PC_W : 12;
    localparam logic [7:0] TMO_LAST = 8'(LOAD_TIMEOUT - 1);

    state_t              state_q;
    logic [15:0]         instr_q;
    logic                pc_load_q;
    logic [PC_W-1:0]     pc_next_q;
    logic [3:0]          rd_addr_a_q, rd_addr_b_q;
    logic                wr_en_q;
    logic [3:0]          wr_addr_q;
    logic [DATA_W-1:0]   wr_data_q;
    logic [2:0]          alu_op_q;
    logic [DATA_W-1:0]   alu_a_q, alu_b_q;
    logic [7:0]          sram_addr_q;
    logic                sram_ren_q, sram_wen_q;
    logic [DATA_W-1:0]   sram_wdata_q;
    logic [DATA_W-1:0]   gpio_q;
    logic [2:0]          flags_q;            // {C,GT,EQ}
    logic                mem_err_q;
    logic [7:0]          tmo_cnt_q;

    logic [3:0]          opcode;
    logic                run_ok, hi_acc, lo_acc;
    logic                take_d;
    logic [PC_W-1:0]     jmp_tgt;

    assign opcode = instr_q[15:12];

`ifdef CU_SEQ_STEP_EN
    logic step_pend_q;
    assign run_ok = !dbg_halt || step_pend_q || dbg_step;

    // Step credit: a dbg_step pulse releases exactly one FETCH_HI while halted.
    always_ff @(posedge clk) begin
        if (rst)         step_pend_q <= 1'b0;
        else if (hi_acc) step_pend_q <= 1'b0;
        else if (dbg_step) step_pend_q <= 1'b1;
    end
`else
    assign run_ok = 1'b1;
`endif

    // pc_inc is raised in the cycle a byte is accepted so the PC advances on that
    // same edge and FETCH_LO already sees the next flash byte.
    assign hi_acc = (state_q == FETCH_HI) && flash_valid && run_ok && !rst;
    assign lo_acc = (state_q == FETCH_LO) && flash_valid && !rst;
    assign pc_inc = hi_acc || lo_acc;

    // Branch decision uses flags latched by an earlier ALU op, not live ALU status.
    always_comb begin
        take_d = 1'b0;
        case (opcode)
            OP_JMP:  take_d = 1'b1;
            OP_BEQ:  take_d = flags_q[0];
            OP_BGT:  take_d = flags_q[1];
            OP_BC:   take_d = flags_q[2];
            default: take_d = 1'b0;
        endcase
    end

    // 12-bit jump field {dst,a,b} zero-extended or truncated to PC_W.
    always_comb begin
        jmp_tgt = '0;
        jmp_tgt[JMP_W-1:0] = instr_q[JMP_W-1:0];
    end

    // Sequencer FSM with all outputs registered; WB outputs are one-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH_HI;
            instr_q      <= '0;
            pc_load_q    <= 1'b0;
            pc_next_q    <= '0;
            rd_addr_a_q  <= '0;
            rd_addr_b_q  <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            alu_op_q     <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            sram_addr_q  <= '0;
            sram_ren_q   <= 1'b0;
            sram_wen_q   <= 1'b0;
            sram_wdata_q <= '0;
            gpio_q       <= '0;
            flags_q      <= '0;
            mem_err_q    <= 1'b0;
            tmo_cnt_q    <= '0;
        end else begin
            pc_load_q  <= 1'b0;
            wr_en_q    <= 1'b0;
            sram_wen_q <= 1'b0;
            case (state_q)
                FETCH_HI: begin
                    if (hi_acc) begin
                        instr_q[15:8] <= flash_data;
                        state_q       <= FETCH_LO;
                    end
                end
                FETCH_LO: begin
                    if (lo_acc) begin
                        instr_q[7:0] <= flash_data;
                        rd_addr_b_q  <= flash_data[3:0];
                        // STORE and OUT read the register named by dst on port A
                        rd_addr_a_q  <= (opcode == OP_STORE || opcode == OP_OUT) ?
                                        instr_q[11:8] : flash_data[7:4];
                        state_q      <= DECODE;
                    end
                end
                DECODE: begin
                    alu_a_q   <= reg_read_data_a;
                    alu_b_q   <= reg_read_data_b;
                    alu_op_q  <= instr_q[15] ? 3'b000 : instr_q[14:12];
                    wr_addr_q <= instr_q[11:8];
                    if (opcode == OP_LOAD || opcode == OP_STORE)
                        sram_addr_q <= instr_q[7:0];
                    if (opcode == OP_LOAD) begin
                        sram_ren_q <= 1'b1;
                        tmo_cnt_q  <= '0;
                        state_q    <= MEM_WAIT;
                    end else begin
                        state_q    <= EXEC;
                    end
                end
                EXEC: begin
                    if (!instr_q[15]) begin
                        wr_data_q <= alu_result;
                        flags_q   <= {alu_cout, alu_gt, alu_eq};
                        wr_en_q   <= 1'b1;
                    end else begin
                        case (opcode)
                            OP_IN: begin
                                wr_data_q <= in_gpio;
                                wr_en_q   <= 1'b1;
                            end
                            OP_STORE: begin
                                sram_wdata_q <= alu_a_q;
                                sram_wen_q   <= 1'b1;
                            end
                            OP_OUT: gpio_q <= alu_a_q;
                            default: begin
                                if (take_d) begin
                                    pc_next_q <= jmp_tgt;
                                    pc_load_q <= 1'b1;
                                end
                            end
                        endcase
                    end
                    state_q <= WB;
                end
                MEM_WAIT: begin
                    tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    if (sram_rvalid) begin
                        wr_data_q  <= sram_read_data;
                        sram_ren_q <= 1'b0;
                        wr_en_q    <= 1'b1;
                        state_q    <= WB;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        wr_data_q  <= '0;
                        mem_err_q  <= 1'b1;
                        sram_ren_q <= 1'b0;
                        wr_en_q    <= 1'b1;
                        state_q    <= WB;
                    end
                end
                WB:      state_q <= FETCH_HI;
                default: state_q <= FETCH_HI;
            endcase
        end
    end

    assign pc_load         = pc_load_q;
    assign pc_next         = pc_next_q;
    assign reg_read_addr_a = rd_addr_a_q;
    assign reg_read_addr_b = rd_addr_b_q;
    assign reg_write_en    = wr_en_q;
    assign reg_write_addr  = wr_addr_q;
    assign reg_write_data  = wr_data_q;
    assign alu_opcode      = alu_op_q;
    assign alu_a           = alu_a_q;
    assign alu_b           = alu_b_q;
    assign sram_addr       = sram_addr_q;
    assign sram_read_en    = sram_ren_q;
    assign sram_write_en   = sram_wen_q;
    assign sram_write_data = sram_wdata_q;
    assign out_gpio        = gpio_q;
    assign flags           = flags_q;
    assign mem_err         = mem_err_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_cu_seq_ctrl.sv
// tb_cu_seq_ctrl: directed bench for cu_seq_ctrl with small PC/flash, register
// file, ALU and SRAM models around the sequencer.
module tb_cu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  flash_data;
    logic        flash_valid;
    logic        pc_inc, pc_load;
    logic [11:0] pc_next;
    logic [3:0]  reg_read_addr_a, reg_read_addr_b;
    logic [7:0]  reg_read_data_a, reg_read_data_b;
    logic        reg_write_en;
    logic [3:0]  reg_write_addr;
    logic [7:0]  reg_write_data;
    logic [2:0]  alu_opcode;
    logic [7:0]  alu_a, alu_b, alu_result;
    logic        alu_eq, alu_gt, alu_cout;
    logic [7:0]  sram_addr;
    logic        sram_read_en, sram_rvalid;
    logic [7:0]  sram_read_data;
    logic        sram_write_en;
    logic [7:0]  sram_write_data;
    logic [7:0]  in_gpio, out_gpio;
    logic [2:0]  flags;
    logic        mem_err;
    logic [2:0]  state_o;

    cu_seq_ctrl #(.DATA_W(8), .PC_W(12), .LOAD_TIMEOUT(15)) dut (
        .clk(clk), .rst(rst),
        .flash_data(flash_data), .flash_valid(flash_valid),
        .pc_inc(pc_inc), .pc_load(pc_load), .pc_next(pc_next),
        .reg_read_addr_a(reg_read_addr_a), .reg_read_addr_b(reg_read_addr_b),
        .reg_read_data_a(reg_read_data_a), .reg_read_data_b(reg_read_data_b),
        .reg_write_en(reg_write_en), .reg_write_addr(reg_write_addr),
        .reg_write_data(reg_write_data),
        .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
        .alu_eq(alu_eq), .alu_gt(alu_gt), .alu_cout(alu_cout),
        .sram_addr(sram_addr), .sram_read_en(sram_read_en), .sram_rvalid(sram_rvalid),
        .sram_read_data(sram_read_data), .sram_write_en(sram_write_en),
        .sram_write_data(sram_write_data),
        .in_gpio(in_gpio), .out_gpio(out_gpio),
        .flags(flags), .mem_err(mem_err), .state_o(state_o)
    );

    // environment models
    logic [7:0]  rom [4096];
    logic [7:0]  rf [16];
    logic [11:0] pc = '0;
    int          rv_delay;
    int          mw_ctr = 0;

    assign flash_data      = rom[pc];
    assign reg_read_data_a = rf[reg_read_addr_a];
    assign reg_read_data_b = rf[reg_read_addr_b];
    assign {alu_cout, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};
    assign alu_eq          = (alu_a == alu_b);
    assign alu_gt          = (alu_a > alu_b);
    assign sram_rvalid     = sram_read_en && (rv_delay >= 0) && (mw_ctr == rv_delay);

    // event logs
    int          wr_cnt = 0, ld_cnt = 0, sw_cnt = 0, both_cnt = 0, mw_cycles = 0, rel_cyc = 0;
    logic [3:0]  last_wa = '0;
    logic [7:0]  last_wd = '0, sw_data = '0, sw_addr = '0, rv_addr = '0;
    logic [11:0] last_tgt = '0;
    logic [2:0]  ld_state = '0;
    logic [31:0] inc_mask = '0, wen_mask = '0;

    // PC model plus logging of every pulse the sequencer issues
    always @(posedge clk) begin
        if (rst)          pc <= '0;
        else if (pc_load) pc <= pc_next;
        else if (pc_inc)  pc <= pc + 12'd1;
        mw_ctr <= sram_read_en ? mw_ctr + 1 : 0;
        if (state_o == 3'd4) mw_cycles <= mw_cycles + 1;
        if (sram_rvalid) rv_addr <= sram_addr;
        if (reg_write_en) begin
            wr_cnt  <= wr_cnt + 1;
            last_wa <= reg_write_addr;
            last_wd <= reg_write_data;
        end
        if (pc_load) begin
            ld_cnt   <= ld_cnt + 1;
            last_tgt <= pc_next;
            ld_state <= state_o;
        end
        if (sram_write_en) begin
            sw_cnt  <= sw_cnt + 1;
            sw_data <= sram_write_data;
            sw_addr <= sram_addr;
        end
        if (pc_inc && pc_load) both_cnt <= both_cnt + 1;
        if (rst) begin
            rel_cyc  <= 0;
            inc_mask <= '0;
            wen_mask <= '0;
        end else begin
            rel_cyc <= rel_cyc + 1;
            if (rel_cyc < 31) begin
                if (pc_inc)       inc_mask[rel_cyc + 1] <= 1'b1;
                if (reg_write_en) wen_mask[rel_cyc + 1] <= 1'b1;
            end
        end
    end

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic put(input logic [11:0] a, input logic [15:0] ins);
        rom[a]         = ins[15:8];
        rom[a + 12'd1] = ins[7:0];
    endtask

    // run one instruction with flash always ready; stop fetching after its WB
    task automatic run_instr();
        flash_valid = 1'b1;
        for (int i = 0; i < 40 && state_o != 3'd5; i++) tick();
        if (state_o != 3'd5) chk("reach_wb", 32'(state_o), 32'd5);
        flash_valid = 1'b0;
        tick();
    endtask

    int w0, m0, s0;

    initial begin
        flash_valid = 1'b0;
        rv_delay    = -1;
        sram_read_data = '0;
        in_gpio     = '0;
        for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
        for (int i = 0; i < 16; i++) rf[i] = 8'h00;
        rf[1] = 8'h05; rf[2] = 8'h07; rf[5] = 8'h3C; rf[7] = 8'h99;
        put(12'h000, 16'h0312);   // ADD R3=R1+R2
        put(12'h002, 16'h0611);   // ADD R6=R1+R1 -> EQ
        put(12'h004, 16'hB123);   // BEQ 0x123
        put(12'h123, 16'h0312);   // ADD clears EQ
        put(12'h125, 16'hB123);   // BEQ not taken
        put(12'h127, 16'h8412);   // LOAD R4,[0x12]
        put(12'h129, 16'h8412);
        put(12'h12B, 16'h8412);
        put(12'h12D, 16'h0312);
        put(12'h12F, 16'hF500);   // OUT R5
        put(12'h131, 16'h0312);
        put(12'h133, 16'h9712);   // STORE R7,[0x12]
        put(12'h135, 16'hE800);   // IN R8
        put(12'h137, 16'hA0F0);   // JMP 0x0F0

        // reset in the middle of an ADD's EXEC
        rst = 1'b1; tick(); tick();
        rst = 1'b0; flash_valid = 1'b1;
        for (int i = 0; i < 10 && state_o != 3'd3; i++) tick();
        chk("reach_exec", 32'(state_o), 32'd3);
        w0 = wr_cnt;
        rst = 1'b1; tick(); tick();
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_outs", 32'(|{pc_inc, pc_load, pc_next, reg_read_addr_a, reg_read_addr_b,
                               reg_write_en, reg_write_addr, reg_write_data, alu_opcode,
                               alu_a, alu_b, sram_addr, sram_read_en, sram_write_en,
                               sram_write_data, out_gpio, flags, mem_err}), 32'd0);
        chk("rst_no_wr", 32'(wr_cnt), 32'(w0));
        rst = 1'b0;

        // ADD 0x0312: pc_inc in cycles 1,2; write in cycle 5
        run_instr();
        chk("add_inc_cyc", inc_mask, 32'h0000_0006);
        chk("add_wen_cyc", wen_mask, 32'h0000_0020);
        chk("add_waddr", 32'(last_wa), 32'h3);
        chk("add_wdata", 32'(last_wd), 32'h0C);
        chk("add_wcnt", 32'(wr_cnt - w0), 32'd1);
        chk("add_flags", 32'(flags), 32'h0);

        run_instr();
        chk("eq_flags", 32'(flags), 32'h1);
        chk("eq_wdata", 32'(last_wd), 32'h0A);

        run_instr();                          // BEQ taken
        chk("beq_ld_cnt", 32'(ld_cnt), 32'd1);
        chk("beq_tgt", 32'(last_tgt), 32'h123);
        chk("beq_ld_state", 32'(ld_state), 32'd5);
        chk("beq_pc", 32'(pc), 32'h123);

        run_instr();
        chk("ne_flags", 32'(flags), 32'h0);
        run_instr();                          // BEQ not taken
        chk("bne_ld_cnt", 32'(ld_cnt), 32'd1);
        chk("bne_pc", 32'(pc), 32'h127);

        // LOAD with rvalid in the 4th MEM_WAIT cycle
        rv_delay = 3; sram_read_data = 8'hA5; m0 = mw_cycles;
        run_instr();
        chk("ld_addr", 32'(rv_addr), 32'h12);
        chk("ld_wa", 32'(last_wa), 32'h4);
        chk("ld_wd", 32'(last_wd), 32'hA5);
        chk("ld_err", 32'(mem_err), 32'h0);
        chk("ld_mw", 32'(mw_cycles - m0), 32'd4);
        chk("ld_ren_off", 32'(sram_read_en), 32'h0);

        // rvalid on the timeout cycle still wins
        rv_delay = 14; sram_read_data = 8'h5A; m0 = mw_cycles;
        run_instr();
        chk("edge_wd", 32'(last_wd), 32'h5A);
        chk("edge_err", 32'(mem_err), 32'h0);
        chk("edge_mw", 32'(mw_cycles - m0), 32'd15);

        // no rvalid: abort after LOAD_TIMEOUT cycles
        rv_delay = -1; m0 = mw_cycles;
        run_instr();
        chk("tmo_wd", 32'(last_wd), 32'h00);
        chk("tmo_wa", 32'(last_wa), 32'h4);
        chk("tmo_err", 32'(mem_err), 32'h1);
        chk("tmo_mw", 32'(mw_cycles - m0), 32'd15);
        chk("tmo_addr", 32'(sram_addr), 32'h12);

        run_instr();
        chk("err_sticky", 32'(mem_err), 32'h1);

        // OUT with a 4-cycle flash stall in FETCH_LO
        chk("gpio_pre", 32'(out_gpio), 32'h0);
        flash_valid = 1'b1; tick();
        flash_valid = 1'b0;
        repeat (4) tick();
        chk("stall_state", 32'(state_o), 32'd1);
        chk("stall_pc", 32'(pc), 32'h130);
        run_instr();
        chk("out_gpio", 32'(out_gpio), 32'h3C);
        run_instr();
        chk("gpio_hold", 32'(out_gpio), 32'h3C);

        s0 = sw_cnt;
        run_instr();                          // STORE
        chk("st_cnt", 32'(sw_cnt - s0), 32'd1);
        chk("st_data", 32'(sw_data), 32'h99);
        chk("st_addr", 32'(sw_addr), 32'h12);

        in_gpio = 8'h77;
        run_instr();                          // IN
        chk("in_wa", 32'(last_wa), 32'h8);
        chk("in_wd", 32'(last_wd), 32'h77);

        run_instr();                          // JMP
        chk("jmp_tgt", 32'(last_tgt), 32'h0F0);
        chk("jmp_pc", 32'(pc), 32'h0F0);
        chk("inc_load_excl", 32'(both_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no end expected finish");
        $fatal(1, "watchdog");
    end

endmodule
